// File: rtl/seg7_digit_monitor.sv
// Reads a 7-segment pattern back into a BCD digit: glitch filter, decoder, and a small
// FSM that classifies each accepted change as step up/down, jump or illegal pattern.
module seg7_digit_monitor #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       step_up,
  output logic       step_down,
  output logic       step_jump,
  output logic       illegal,
  output logic [7:0] jump_cnt
);

  localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {EMPTY, LOCKED, FAULT} state_t;

  state_t        state_q, state_d;
  logic [6:0]    cand_q, cand_d;
  logic [CW-1:0] stab_cnt_q, stab_cnt_d;
  logic [6:0]    acc_pat_q, acc_pat_d;
  logic          acc_none_q, acc_none_d;
  logic [3:0]    digit_d;
  logic [7:0]    jump_cnt_d;
  logic          step_up_d, step_down_d, step_jump_d, illegal_d;

  logic          accept;
  logic          code_legal;
  logic [3:0]    code;
  logic [3:0]    digit_inc, digit_dec;

  always_comb begin
    code_legal = 1'b1;
    code       = 4'd0;
    unique case (seg_in)
      7'h7E: code = 4'd0;
      7'h30: code = 4'd1;
      7'h6D: code = 4'd2;
      7'h79: code = 4'd3;
      7'h33: code = 4'd4;
      7'h5B: code = 4'd5;
      7'h5F: code = 4'd6;
      7'h70: code = 4'd7;
      7'h7F: code = 4'd8;
      7'h7B: code = 4'd9;
      default: code_legal = 1'b0;
    endcase
  end

  assign digit_inc = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  assign digit_dec = (digit == 4'd0) ? 4'd9 : digit - 4'd1;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    cand_d      = cand_q;
    stab_cnt_d  = stab_cnt_q;
    acc_pat_d   = acc_pat_q;
    acc_none_d  = acc_none_q;
    state_d     = state_q;
    digit_d     = digit;
    jump_cnt_d  = jump_cnt;
    step_up_d   = 1'b0;
    step_down_d = 1'b0;
    step_jump_d = 1'b0;
    illegal_d   = 1'b0;
    accept      = 1'b0;

    if (seg_valid) begin
      if (seg_in != cand_q) begin
        cand_d     = seg_in;
        stab_cnt_d = CW'(1);
      end else if (stab_cnt_q < CW'(STABLE_CYCLES)) begin
        stab_cnt_d = stab_cnt_q + CW'(1);
      end
      // A held pattern matches acc_pat after its first accept, so it never fires twice.
      accept = (stab_cnt_d == CW'(STABLE_CYCLES)) && (acc_none_q || (seg_in != acc_pat_q));
    end

    if (accept) begin
      acc_pat_d  = seg_in;
      acc_none_d = 1'b0;
      if (!code_legal) begin
        state_d   = FAULT;
        illegal_d = 1'b1;
      end else begin
        state_d = LOCKED;
        digit_d = code;
        if (state_q == LOCKED) begin
          if (code == digit_inc) begin
            step_up_d = 1'b1;
          end else if (code == digit_dec) begin
            step_down_d = 1'b1;
          end else begin
            step_jump_d = 1'b1;
            if (jump_cnt != 8'hFF) jump_cnt_d = jump_cnt + 8'd1;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      cand_q     <= 7'd0;
      stab_cnt_q <= '0;
      acc_pat_q  <= 7'd0;
      acc_none_q <= 1'b1;
      digit      <= 4'd0;
      jump_cnt   <= 8'd0;
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      step_jump  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      stab_cnt_q <= stab_cnt_d;
      acc_pat_q  <= acc_pat_d;
      acc_none_q <= acc_none_d;
      digit      <= digit_d;
      jump_cnt   <= jump_cnt_d;
      step_up    <= step_up_d;
      step_down  <= step_down_d;
      step_jump  <= step_jump_d;
      illegal    <= illegal_d;
    end
  end

  assign digit_valid = (state_q == LOCKED);

endmodule

// File: tb/tb_seg7_digit_monitor.sv
// Self-checking bench for seg7_digit_monitor: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a run-length behavioural model.
module tb_seg7_digit_monitor;

  localparam int STABLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       seg_valid;
  logic [3:0] digit;
  logic       digit_valid, step_up, step_down, step_jump, illegal;
  logic [7:0] jump_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  seg7_digit_monitor #(.STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .digit      (digit),
    .digit_valid(digit_valid),
    .step_up    (step_up),
    .step_down  (step_down),
    .step_jump  (step_jump),
    .illegal    (illegal),
    .jump_cnt   (jump_cnt)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_codes [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (seg_codes[i] == p) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a pattern is accepted when its run of consecutive enabled samples reaches
  // exactly STABLE and it differs from the last accepted pattern.
  bit m_seen_rst = 0;
  int m_prev, m_run, m_acc, m_digit, m_jumps, m_s, m_d;
  bit m_locked, m_up, m_down, m_jump, m_ill;

  always @(posedge clk) begin
    m_up = 0; m_down = 0; m_jump = 0; m_ill = 0;
    if (rst) begin
      m_seen_rst = 1;
      m_prev = -1; m_run = 0; m_acc = -1;
      m_locked = 0; m_digit = 0; m_jumps = 0;
    end else if (m_seen_rst && seg_valid) begin
      m_s = int'(seg_in);
      if (m_s == m_prev) m_run++;
      else begin
        m_prev = m_s;
        m_run  = 1;
      end
      if (m_run == STABLE && m_s != m_acc) begin
        m_acc = m_s;
        m_d   = decode(seg_in);
        if (m_d < 0) begin
          m_ill    = 1;
          m_locked = 0;
        end else begin
          if (m_locked) begin
            if (m_d == (m_digit + 1) % 10)      m_up = 1;
            else if (m_d == (m_digit + 9) % 10) m_down = 1;
            else begin
              m_jump = 1;
              m_jumps++;
            end
          end
          m_digit  = m_d;
          m_locked = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_seen_rst) begin
      check("model_digit", 8'(digit), 8'(m_digit));
      check("model_digit_valid", 8'(digit_valid), 8'(m_locked));
      check("model_step_up", 8'(step_up), 8'(m_up));
      check("model_step_down", 8'(step_down), 8'(m_down));
      check("model_step_jump", 8'(step_jump), 8'(m_jump));
      check("model_illegal", 8'(illegal), 8'(m_ill));
      check("model_jump_cnt", jump_cnt, (m_jumps > 255) ? 8'hFF : 8'(m_jumps));
    end
  end

  task automatic apply(input logic [6:0] s, input logic v);
    seg_in    = s;
    seg_valid = v;
    @(negedge clk);
  endtask

  // pulses = {step_up, step_down, step_jump, illegal}
  task automatic pin(input string tag, input logic [3:0] d, input logic dv,
                     input logic [3:0] pulses, input logic [7:0] jc);
    check({tag, "_digit"}, 8'(digit), 8'(d));
    check({tag, "_valid"}, 8'(digit_valid), 8'(dv));
    check({tag, "_pulses"}, 8'({step_up, step_down, step_jump, illegal}), 8'(pulses));
    check({tag, "_jump_cnt"}, jump_cnt, jc);
  endtask

  logic [6:0] cur;

  initial begin
    rst = 1'b1; seg_in = 7'h00; seg_valid = 1'b0;
    apply(7'h00, 1'b0);
    apply(7'h00, 1'b0);
    pin("reset", 4'd0, 1'b0, 4'b0000, 8'd0);
    rst = 1'b0;

    apply(7'h7E, 1'b1); pin("fill", 4'd0, 1'b0, 4'b0000, 8'd0);
    apply(7'h7E, 1'b1); pin("lock0", 4'd0, 1'b1, 4'b0000, 8'd0);
    apply(7'h30, 1'b1); pin("half", 4'd0, 1'b1, 4'b0000, 8'd0);
    apply(7'h30, 1'b1); pin("up01", 4'd1, 1'b1, 4'b1000, 8'd0);
    apply(7'h7E, 1'b1); apply(7'h7E, 1'b1); pin("dn10", 4'd0, 1'b1, 4'b0100, 8'd0);
    apply(7'h7B, 1'b1); apply(7'h7B, 1'b1); pin("dn09", 4'd9, 1'b1, 4'b0100, 8'd0);
    apply(7'h7E, 1'b1); apply(7'h7E, 1'b1); pin("up90", 4'd0, 1'b1, 4'b1000, 8'd0);
    apply(7'h7E, 1'b1); pin("hold", 4'd0, 1'b1, 4'b0000, 8'd0);

    apply(7'h30, 1'b1); apply(7'h7E, 1'b1); apply(7'h7E, 1'b1);
    pin("glitch", 4'd0, 1'b1, 4'b0000, 8'd0);

    apply(7'h30, 1'b1); apply(7'h30, 1'b0); apply(7'h30, 1'b0);
    pin("gap_mid", 4'd0, 1'b1, 4'b0000, 8'd0);
    apply(7'h30, 1'b1); pin("gap_acc", 4'd1, 1'b1, 4'b1000, 8'd0);

    apply(7'h6D, 1'b1); apply(7'h6D, 1'b1); pin("up12", 4'd2, 1'b1, 4'b1000, 8'd0);
    apply(7'h5B, 1'b1); apply(7'h5B, 1'b1); pin("jump25", 4'd5, 1'b1, 4'b0010, 8'd1);

    apply(7'h00, 1'b1); apply(7'h00, 1'b1); pin("illegal", 4'd5, 1'b0, 4'b0001, 8'd1);
    apply(7'h00, 1'b1); pin("ill_hold", 4'd5, 1'b0, 4'b0000, 8'd1);
    apply(7'h6D, 1'b1); apply(7'h6D, 1'b1); pin("fault_exit", 4'd2, 1'b1, 4'b0000, 8'd1);

    // 2 <-> 5 alternation: 260 more jumps, well past saturation.
    for (int i = 0; i < 130; i++) begin
      apply(7'h5B, 1'b1); apply(7'h5B, 1'b1);
      apply(7'h6D, 1'b1); apply(7'h6D, 1'b1);
    end
    pin("saturate", 4'd2, 1'b1, 4'b0010, 8'hFF);

    apply(7'h30, 1'b1);
    rst = 1'b1;
    apply(7'h30, 1'b1); pin("mid_rst", 4'd0, 1'b0, 4'b0000, 8'd0);
    rst = 1'b0;
    apply(7'h30, 1'b1); apply(7'h30, 1'b1); pin("post_rst", 4'd1, 1'b1, 4'b0000, 8'd0);

    cur = 7'h7E;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) < 8) cur = seg_codes[$urandom_range(0, 9)];
        else                          cur = 7'($urandom_range(0, 127));
      end
      rst = ($urandom_range(0, 299) == 0);
      apply(cur, ($urandom_range(0, 4) != 0));
    end
    rst = 1'b0;
    apply(cur, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
